// File: rtl/xlib_xyz_dma_unpack.sv
// ---------------------------------------------------------------------------
// xlib_xyz_dma_unpack
//
// Width down-converter for the DMA read stream. Each wide word accepted from
// the DMA output FIFO is held in a register and replayed as narrower slices,
// least significant slice first. The final word of a frame can be partial.
// Its valid-byte count comes from a PIO-programmed tail register, where
// tail = 0 means the whole word is valid.
//
// Parameters
//   AL  log2 of input bytes per word   (DW = 8*2**AL)
//   OL  log2 of output bytes per slice (OW = 8*2**OL), OL <= AL
//   CW  width of the completed-frame counter
//
// Ports
//   clk, rst     single clock, asynchronous active-high reset
//   pio_len_we   tail register write strobe; data taken from pio_d[AL-1:0]
//   pio_d        PIO write data
//   pio_tail     tail register readback, zero-extended to 32 bits
//   in_rdy/val   input handshake (DMA side)
//   in_eof       marks the last word of a frame
//   in_d         input word, DW bits
//   out_rdy/val  output handshake (consumer side)
//   out_eof      marks the last slice of a frame
//   out_d        output slice, OW bits
//   busy         holding register occupied
//   frm_cnt      completed-frame counter, wraps
// ---------------------------------------------------------------------------
module xlib_xyz_dma_unpack #(
  parameter int AL = 2,
  parameter int OL = 0,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pio_len_we,
  input  logic [31:0]          pio_d,
  output logic [31:0]          pio_tail,
  output logic                 in_rdy,
  input  logic                 in_val,
  input  logic                 in_eof,
  input  logic [8*(2**AL)-1:0] in_d,
  input  logic                 out_rdy,
  output logic                 out_val,
  output logic                 out_eof,
  output logic [8*(2**OL)-1:0] out_d,
  output logic                 busy,
  output logic [CW-1:0]        frm_cnt
);

  localparam int DW = 8 * (2 ** AL);
  localparam int OW = 8 * (2 ** OL);
  localparam int N  = 2 ** (AL - OL);
  localparam int OB = 2 ** OL;
  localparam int IW = (AL - OL > 0) ? (AL - OL) : 1;
  localparam int TW = (AL > 0) ? AL : 1;

  localparam logic [IW-1:0] NSL_FULL = IW'(N - 1);

  logic [DW-1:0] hold;
  logic          full;
  logic [IW-1:0] idx;
  logic [IW-1:0] nsl;
  logic          eof_r;
  logic [TW-1:0] tail;

  logic          last_slice;
  logic          capture;
  logic          out_xfer;
  logic [31:0]   tail_slices;
  logic [IW-1:0] cap_nsl;

  assign last_slice = (idx == nsl);
  assign in_rdy     = ~full | (out_rdy & last_slice);
  assign capture    = in_val & in_rdy;
  assign out_xfer   = full & out_rdy;

  assign out_val  = full;
  assign busy     = full;
  assign out_eof  = full & eof_r & last_slice;
  assign pio_tail = 32'(tail);

  // Slice count of a partial tail word rounds up; upper bytes of the last
  // slice are don't-care.
  always_comb begin
    tail_slices = (32'(tail) + 32'(OB - 1)) >> OL;
    cap_nsl     = NSL_FULL;
    if (in_eof && (tail != '0))
      cap_nsl = IW'(tail_slices - 32'd1);
  end

  always_comb begin
    out_d = OW'(hold >> (32'(idx) * 32'(OW)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold    <= '0;
      full    <= 1'b0;
      idx     <= '0;
      nsl     <= '0;
      eof_r   <= 1'b0;
      tail    <= '0;
      frm_cnt <= '0;
    end else begin
      // Capture samples the tail value from before any same-cycle PIO write.
      if (pio_len_we)
        tail <= (AL > 0) ? pio_d[TW-1:0] : '0;

      if (out_xfer && out_eof)
        frm_cnt <= frm_cnt + CW'(1);

      if (capture) begin
        hold  <= in_d;
        full  <= 1'b1;
        idx   <= '0;
        nsl   <= cap_nsl;
        eof_r <= in_eof;
      end else if (out_xfer) begin
        if (!last_slice) begin
          if (N > 1)
            idx <= idx + IW'(1);
        end else begin
          full <= 1'b0;
        end
      end
    end
  end

endmodule
